alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational ALU (4-bit a/b, 3-bit sel, 5-bit out) between two requesters.
- Round-robin grant; one operation in flight at a time.
- Operands and sel are registered and driven to the external ALU; the ALU result is captured one cycle later.
- The result is returned on one shared response channel, tagged with the requester id.

Parameters:
DW, 4, operand width (ALU a/b)
SW, 3, opcode/select width (ALU sel)
RW, DW+1, result width (ALU out)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 accepted this cycle
req0_a / req0_b  input  DW  requester 0 operands
req0_sel  input  SW  requester 0 opcode
req1_valid, req1_ready, req1_a, req1_b, req1_sel  as above, requester 1
alu_a / alu_b  output  DW  registered operands to the ALU
alu_sel  output  SW  registered opcode to the ALU
alu_out  input  RW  ALU result, combinational from alu_a/alu_b/alu_sel
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result
rsp_id  output  1  requester that owns the result
rsp_data  output  RW  captured ALU result

Behaviour:
- Reset (async, reset_n=0): state=IDLE; rsp_valid=0; rsp_id=0; rsp_data=0; alu_a=alu_b=0; alu_sel=0; last_grant=1, so requester 0 wins first.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: 1 only for the granted requester, only in IDLE.
  - Grant: if both valid, grant the requester that is not last_grant; if one valid, grant it; if none, stay in IDLE.
  - On handshake (valid && ready): latch a/b/sel into alu_* regs, latch id, set last_grant=id, go to EXEC.
- EXEC (exactly 1 cycle): ALU settles; rsp_data <= alu_out; rsp_id <= latched id; rsp_valid <= 1; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id held stable.
  - When rsp_ready=1: rsp_valid <= 0, go to IDLE.
  - If rsp_ready is held low, the block stalls indefinitely and reqN_ready stays 0.
- Latency: handshake at edge T → rsp_valid high from edge T+2. Minimum 3 cycles per operation when rsp_ready is tied high.
- Requester rule: valid must stay high and payload stable until ready. The block samples only on the handshake cycle.
- Widths: alu_out passed through unmodified (RW bits). No arithmetic is performed in this block. All 2^SW opcodes are forwarded; no illegal-op filtering.
- alu_* registers hold their last values in IDLE and RESP (no toggling when idle).
- Simultaneous: req0 and req1 valid in the same cycle are resolved by round-robin only. A requester re-asserting valid in the same cycle its response is accepted is considered next IDLE cycle.
- Reset mid-operation (EXEC or RESP): in-flight op is dropped, no response is produced, and all outputs return to reset values immediately.

Optional Feature:
Macro ALU_ARB_STATS_EN.
- Defined: adds outputs cnt0, cnt1 (8 bits each). cntN increments when a response with rsp_id=N completes (rsp_valid && rsp_ready). Counters saturate at 255 and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package alu_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2;
  - default widths DW/SW/RW;
  - counter width 8.
- One sub-module, rr_arb2:
  - inputs: two valids, last_grant, enable;
  - outputs: one-hot grant and granted id;
  - purely combinational.
- The FSM and registers live in alu_arbiter. The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- The bench ALU stub computes out=a+b. Reset, then req0 valid with a=3, b=2, sel=000 → req0_ready=1 same cycle; alu_a=3, alu_b=2, alu_sel=000 next cycle; rsp_valid at T+2 with rsp_id=0, rsp_data=5'd5.
- req0 and req1 valid together for 4 operations (req0 a=1, b=1; req1 a=7, b=8), rsp_ready=1 → grants alternate 0,1,0,1; rsp_data alternates 2,15.
- rsp_ready=0 for 5 cycles after rsp_valid → rsp_data and rsp_id stable; req0_ready and req1_ready stay 0; a new req1 waits, then is accepted in the IDLE cycle after rsp_ready=1.
- req1 alone repeatedly (a=15, b=15, sel=111) → always granted with no starvation; rsp_data=5'd30 each time; 3-cycle period.
- Assert reset_n=0 during EXEC → rsp_valid=0 and alu_a/b/sel=0 immediately. After release, requester 0 wins a simultaneous request.
- With ALU_ARB_STATS_EN, 300 req0 operations → cnt0=255 (saturated), cnt1=0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared constants and state encoding for the two-requester ALU arbiter.
// Optional statistics counters are enabled by defining ALU_ARB_STATS_EN.
package alu_arb_pkg;

    localparam int ALU_DW = 4;
    localparam int ALU_SW = 3;
    localparam int ALU_RW = ALU_DW + 1;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: when both request, the one that
// was not granted last wins; grants are suppressed while enable_i is low.
module rr_arb2 (
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_grant_i,
    input  logic       enable_i,
    output logic [1:0] grant_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_id_o = 1'b0;
        grant_o  = 2'b00;
        if (valid0_i && valid1_i) begin
            gnt_id_o = ~last_grant_i;
        end else if (valid1_i) begin
            gnt_id_o = 1'b1;
        end
        if (enable_i && (valid0_i || valid1_i)) begin
            grant_o = gnt_id_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, one op in flight.
// Define ALU_ARB_STATS_EN to add saturating per-requester completion counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int SW = ALU_SW,
    parameter int RW = DW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [DW-1:0]    req0_a,
    input  logic [DW-1:0]    req0_b,
    input  logic [SW-1:0]    req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [DW-1:0]    req1_a,
    input  logic [DW-1:0]    req1_b,
    input  logic [SW-1:0]    req1_sel,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    output logic [SW-1:0]    alu_sel,
    input  logic [RW-1:0]    alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [RW-1:0]    rsp_data
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    state_e        state_q, state_d;
    logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [SW-1:0] alu_sel_q, alu_sel_d;
    logic          id_q, id_d;
    logic          last_grant_q, last_grant_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic [RW-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]    grant;
    logic          gnt_id;

    rr_arb2 u_arb (
        .valid0_i     (req0_valid),
        .valid1_i     (req1_valid),
        .last_grant_i (last_grant_q),
        .enable_i     (state_q == ST_IDLE),
        .grant_o      (grant),
        .gnt_id_o     (gnt_id)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                // A grant implies the granted requester is valid, so it is a handshake.
                if (|grant) begin
                    alu_a_d      = gnt_id ? req1_a   : req0_a;
                    alu_b_d      = gnt_id ? req1_b   : req0_b;
                    alu_sel_d    = gnt_id ? req1_sel : req0_sel;
                    id_d         = gnt_id;
                    last_grant_d = gnt_id;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_out;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else if (rsp_valid_q && rsp_ready && (rsp_id_q == (gi == 1))
                         && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
    assign cnt0 = g_cnt[0].cnt_q;
    assign cnt1 = g_cnt[1].cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with an a+b ALU stub; covers counters
// only when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0] req0_sel = '0, req1_sel = '0;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [4:0] alu_out;
    logic       rsp_valid, rsp_id;
    logic       rsp_ready = 1'b1;
    logic [4:0] rsp_data;
`ifdef ALU_ARB_STATS_EN
    logic [7:0] cnt0, cnt1;
`endif

    typedef struct packed {
        logic       id;
        logic [4:0] data;
    } exp_t;

    exp_t sb[$];
    int   glog[$];
    int   hcyc[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign alu_out = {1'b0, alu_a} + {1'b0, alu_b};

    alu_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef ALU_ARB_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got timeout, expected event (t=%0t)", name, $time);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every accepted response is popped and compared against the scoreboard.
    always @(negedge clock) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_data), 32'h7fff_ffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
    end

    task automatic push_exp(input logic id, input logic [4:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic run_ops(input int n0, input int n1,
                           input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] s0,
                           input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] s1);
        int  q0 = n0;
        int  q1 = n1;
        int  budget = 4 * (n0 + n1) + 20;
        logic g0, g1;
        req0_a = a0; req0_b = b0; req0_sel = s0;
        req1_a = a1; req1_b = b1; req1_sel = s1;
        req0_valid = (q0 > 0);
        req1_valid = (q1 > 0);
        while ((q0 > 0 || q1 > 0) && budget > 0) begin
            @(negedge clock);
            g0 = req0_ready;
            g1 = req1_ready;
            if (g0) begin glog.push_back(0); hcyc.push_back(cyc); end
            if (g1) begin glog.push_back(1); hcyc.push_back(cyc); end
            next_cycle();
            if (g0) q0--;
            if (g1) q1--;
            req0_valid = (q0 > 0);
            req1_valid = (q1 > 0);
            budget--;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (budget == 0) timeout("run_ops");
    endtask

    task automatic drain();
        int budget = 60;
        while (sb.size() != 0 && budget > 0) begin
            next_cycle();
            budget--;
        end
        if (sb.size() != 0) timeout("drain");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        // Reset values
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_alu_a", 32'(alu_a), 0);
        chk("rst_alu_sel", 32'(alu_sel), 0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        next_cycle();

        // Single op: 3+2, latency T -> alu regs T+1 -> rsp T+2
        req0_a = 4'd3; req0_b = 4'd2; req0_sel = 3'b000; req0_valid = 1'b1;
        push_exp(1'b0, 5'd5);
        @(negedge clock);
        chk("t1_req0_ready", 32'(req0_ready), 1);
        chk("t1_req1_ready", 32'(req1_ready), 0);
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clock);
        chk("t1_alu_a", 32'(alu_a), 3);
        chk("t1_alu_b", 32'(alu_b), 2);
        chk("t1_alu_sel", 32'(alu_sel), 0);
        chk("t1_rsp_valid_exec", 32'(rsp_valid), 0);
        next_cycle();
        @(negedge clock);
        chk("t1_rsp_valid_T2", 32'(rsp_valid), 1);
        next_cycle();
        drain();

        // req1 alone: always granted, 30 each, 3-cycle period
        glog.delete(); hcyc.delete();
        for (int i = 0; i < 4; i++) push_exp(1'b1, 5'd30);
        run_ops(0, 4, 4'd0, 4'd0, 3'd0, 4'd15, 4'd15, 3'b111);
        chk("t2_grants", 32'(glog.size()), 4);
        for (int i = 0; i < glog.size(); i++) chk("t2_grant_id", 32'(glog[i]), 1);
        for (int i = 1; i < hcyc.size(); i++) chk("t2_period", 32'(hcyc[i] - hcyc[i-1]), 3);
        drain();

        // Both valid: alternate 0,1,0,1
        glog.delete(); hcyc.delete();
        for (int i = 0; i < 2; i++) begin
            push_exp(1'b0, 5'd2);
            push_exp(1'b1, 5'd15);
        end
        run_ops(2, 2, 4'd1, 4'd1, 3'd0, 4'd7, 4'd8, 3'd0);
        chk("t3_grants", 32'(glog.size()), 4);
        for (int i = 0; i < glog.size(); i++) chk("t3_grant_order", 32'(glog[i]), 32'(i % 2));
        drain();

        // Back-pressure: response held, new req1 waits
        rsp_ready = 1'b0;
        req0_a = 4'd5; req0_b = 4'd6; req0_sel = 3'd2; req0_valid = 1'b1;
        push_exp(1'b0, 5'd11);
        @(negedge clock);
        chk("t4_req0_ready", 32'(req0_ready), 1);
        next_cycle();
        req0_valid = 1'b0;
        budget = 10;
        while (budget > 0) begin
            @(negedge clock);
            if (rsp_valid) break;
            next_cycle();
            budget--;
        end
        if (budget == 0) timeout("t4_rsp_valid");
        next_cycle();
        req1_a = 4'd4; req1_b = 4'd9; req1_sel = 3'd1; req1_valid = 1'b1;
        push_exp(1'b1, 5'd13);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t4_stall_valid", 32'(rsp_valid), 1);
            chk("t4_stall_data", 32'(rsp_data), 11);
            chk("t4_stall_id", 32'(rsp_id), 0);
            chk("t4_stall_rdy1", 32'(req1_ready), 0);
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("t4_rdy1_in_resp", 32'(req1_ready), 0);
        next_cycle();
        @(negedge clock);
        chk("t4_rdy1_next_idle", 32'(req1_ready), 1);
        next_cycle();
        req1_valid = 1'b0;
        drain();

        // Reset during EXEC drops the op; afterwards req0 wins again
        req0_a = 4'd1; req0_b = 4'd2; req0_sel = 3'd5; req0_valid = 1'b1;
        @(negedge clock);
        chk("t5_req0_ready", 32'(req0_ready), 1);
        next_cycle();
        req0_valid = 1'b0;
        chk("t5_alu_sel_exec", 32'(alu_sel), 5);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("t5_rst_alu_a", 32'(alu_a), 0);
        chk("t5_rst_alu_b", 32'(alu_b), 0);
        chk("t5_rst_alu_sel", 32'(alu_sel), 0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        glog.delete();
        push_exp(1'b0, 5'd2);
        push_exp(1'b1, 5'd15);
        run_ops(1, 1, 4'd1, 4'd1, 3'd0, 4'd7, 4'd8, 3'd0);
        chk("t5_first_grant", 32'(glog.size() > 0 ? glog[0] : 9), 0);
        drain();

`ifdef ALU_ARB_STATS_EN
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        chk("t6_cnt0_rst", 32'(cnt0), 0);
        chk("t6_cnt1_rst", 32'(cnt1), 0);
        for (int i = 0; i < 300; i++) push_exp(1'b0, 5'd3);
        run_ops(300, 0, 4'd1, 4'd2, 3'd3, 4'd0, 4'd0, 3'd0);
        drain();
        next_cycle();
        chk("t6_cnt0_sat", 32'(cnt0), 255);
        chk("t6_cnt1", 32'(cnt1), 0);
`endif

        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
